// File: rtl/demux_1to4_buf_if.sv
// Bus bundle for demux_1to4_buf: one producer port fanned out to four
// single-entry channel buffers, each with its own valid/ready pair.
interface demux_1to4_buf_if #(
    parameter int size = 32
);
    logic [size-1:0] data_i;
    logic [1:0]      select_i;
    logic            valid_i;
    logic            ready_o;
    logic [size-1:0] data0_o;
    logic [size-1:0] data1_o;
    logic [size-1:0] data2_o;
    logic [size-1:0] data3_o;
    logic [3:0]      valid_o;
    logic [3:0]      ready_i;
    logic [15:0]     stall_cnt_o;

    modport master (
        output data_i, select_i, valid_i, ready_i,
        input  ready_o, data0_o, data1_o, data2_o, data3_o, valid_o, stall_cnt_o
    );

    modport slave (
        input  data_i, select_i, valid_i, ready_i,
        output ready_o, data0_o, data1_o, data2_o, data3_o, valid_o, stall_cnt_o
    );
endinterface

// File: rtl/demux_1to4_buf.sv
// 1-to-4 demultiplexer with a registered one-word buffer per channel and a
// saturating counter of producer stall cycles.
module demux_1to4_buf #(
    parameter int size = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    demux_1to4_buf_if.slave bus
);
    logic [size-1:0] data_p0 [4];
    logic [3:0]      vld_p0;
    logic [15:0]     stall_cnt;
    logic            ready;
    logic            accept;
    logic            stall;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A full channel can still take a word in the cycle its consumer drains it.
    assign ready  = !rst_i && (!vld_p0[bus.select_i] || bus.ready_i[bus.select_i]);
    assign accept = bus.valid_i && ready;
    assign stall  = bus.valid_i && !ready && !rst_i;

    // Input -> channel buffer stage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_p0    <= 4'b0000;
            stall_cnt <= 16'h0000;
            for (int k = 0; k < 4; k++) begin
                data_p0[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (accept && (bus.select_i == 2'(k))) begin
                    data_p0[k] <= bus.data_i;
                    vld_p0[k]  <= 1'b1;
                end else if (bus.ready_i[k]) begin
                    vld_p0[k]  <= 1'b0;
                end
            end
            if (stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

    assign bus.ready_o     = ready;
    assign bus.valid_o     = vld_p0;
    assign bus.data0_o     = data_p0[0];
    assign bus.data1_o     = data_p0[1];
    assign bus.data2_o     = data_p0[2];
    assign bus.data3_o     = data_p0[3];
    assign bus.stall_cnt_o = stall_cnt;
endmodule

// File: tb/tb_demux_1to4_buf.sv
// Bench for demux_1to4_buf: directed vector table, long stall saturation run,
// and randomized traffic against a behavioural channel model.
module tb_demux_1to4_buf;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    demux_1to4_buf_if #(.size(32)) bus ();

    demux_1to4_buf #(.size(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rst;
        bit        vin;
        bit [1:0]  sel;
        bit [31:0] din;
        bit [3:0]  rdy;
        bit        ex_ready;
        bit [3:0]  ex_valid;
        bit [15:0] ex_stall;
        int        ch;
        bit [31:0] ex_data;
    } vec_t;

    vec_t tbl [18];

    // behavioural model state
    bit [31:0] m_data [4];
    bit        m_full [4];
    int        m_stall;
    bit        m_ready;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] dout(input int ch);
        case (ch)
            0: return bus.data0_o;
            1: return bus.data1_o;
            2: return bus.data2_o;
            default: return bus.data3_o;
        endcase
    endfunction

    function automatic logic [3:0] m_valid_vec();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = m_full[k];
        return v;
    endfunction

    function automatic bit model_ready(input bit r, input bit [1:0] s, input bit [3:0] rd);
        return !r && (!m_full[s] || rd[s]);
    endfunction

    // Apply one cycle of inputs: check ready_o, advance the model, check registered outputs.
    task automatic step(input bit r, input bit v, input bit [1:0] s, input bit [31:0] d,
                        input bit [3:0] rd, input bit full_check);
        rst = r;
        bus.valid_i  = v;
        bus.select_i = s;
        bus.data_i   = d;
        bus.ready_i  = rd;
        #1;
        m_ready = model_ready(r, s, rd);
        if (full_check) chk("ready_o", bus.ready_o, m_ready);
        if (r) begin
            for (int k = 0; k < 4; k++) begin
                m_full[k] = 0;
                m_data[k] = 0;
            end
            m_stall = 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (v && m_ready && s == 2'(k)) begin
                    m_data[k] = d;
                    m_full[k] = 1;
                end else if (rd[k]) begin
                    m_full[k] = 0;
                end
            end
            if (v && !m_ready && m_stall < 65535) m_stall++;
        end
        @(posedge clk);
        #1;
        if (full_check) begin
            chk("valid_o", bus.valid_o, m_valid_vec());
            chk("stall_cnt_o", bus.stall_cnt_o, 16'(m_stall));
            for (int k = 0; k < 4; k++) chk($sformatf("data%0d_o", k), dout(k), m_data[k]);
        end
    endtask

    initial begin
        bus.valid_i  = 0;
        bus.select_i = 0;
        bus.data_i   = 0;
        bus.ready_i  = 0;
        for (int k = 0; k < 4; k++) begin
            m_data[k] = 0;
            m_full[k] = 0;
        end
        m_stall = 0;

        //          rst vin sel din           rdy     rdy_o valid    stall ch data
        tbl[0]  = '{1, 0, 0, 32'h0,          4'b0000, 0, 4'b0000, 0, 0, 32'h0};
        tbl[1]  = '{0, 1, 2, 32'hA5A5_0001,  4'b0000, 1, 4'b0100, 0, 2, 32'hA5A5_0001};
        tbl[2]  = '{0, 1, 1, 32'h11,         4'b0000, 1, 4'b0110, 0, 1, 32'h11};
        tbl[3]  = '{0, 1, 1, 32'hBAD,        4'b0000, 0, 4'b0110, 1, 1, 32'h11};
        tbl[4]  = '{0, 1, 1, 32'hBAD,        4'b0000, 0, 4'b0110, 2, 1, 32'h11};
        tbl[5]  = '{0, 1, 1, 32'hBAD,        4'b0000, 0, 4'b0110, 3, 1, 32'h11};
        tbl[6]  = '{0, 1, 3, 32'h77,         4'b0000, 1, 4'b1110, 3, 3, 32'h77};
        tbl[7]  = '{0, 1, 3, 32'h33,         4'b1000, 1, 4'b1110, 3, 3, 32'h33};
        tbl[8]  = '{1, 0, 0, 32'h0,          4'b0000, 0, 4'b0000, 0, 3, 32'h0};
        tbl[9]  = '{0, 1, 0, 32'h1,          4'b0000, 1, 4'b0001, 0, 0, 32'h1};
        tbl[10] = '{0, 1, 1, 32'h2,          4'b0000, 1, 4'b0011, 0, 1, 32'h2};
        tbl[11] = '{0, 1, 2, 32'h3,          4'b0000, 1, 4'b0111, 0, 2, 32'h3};
        tbl[12] = '{0, 1, 3, 32'h4,          4'b0000, 1, 4'b1111, 0, 3, 32'h4};
        tbl[13] = '{0, 0, 0, 32'hDEAD,       4'b1111, 1, 4'b0000, 0, 2, 32'h3};
        tbl[14] = '{0, 1, 0, 32'h5,          4'b0000, 1, 4'b0001, 0, 0, 32'h5};
        tbl[15] = '{0, 1, 1, 32'h6,          4'b0000, 1, 4'b0011, 0, 1, 32'h6};
        tbl[16] = '{0, 1, 3, 32'h8,          4'b0000, 1, 4'b1011, 0, 3, 32'h8};
        tbl[17] = '{1, 1, 2, 32'h9,          4'b0000, 0, 4'b0000, 0, 0, 32'h0};

        @(posedge clk);
        #1;
        for (int i = 0; i < 18; i++) begin
            rst = tbl[i].rst;
            bus.valid_i  = tbl[i].vin;
            bus.select_i = tbl[i].sel;
            bus.data_i   = tbl[i].din;
            bus.ready_i  = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d ready_o", i), bus.ready_o, tbl[i].ex_ready);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d valid_o", i), bus.valid_o, tbl[i].ex_valid);
            chk($sformatf("vec%0d stall_cnt_o", i), bus.stall_cnt_o, tbl[i].ex_stall);
            chk($sformatf("vec%0d data%0d_o", i, tbl[i].ch), dout(tbl[i].ch), tbl[i].ex_data);
        end
        chk("post-reset data1_o", bus.data1_o, 32'h0);
        chk("post-reset data3_o", bus.data3_o, 32'h0);

        // Saturation: channel 0 full and blocked, producer keeps pushing.
        step(1, 0, 0, 0, 4'b0000, 0);
        step(0, 1, 0, 32'hC0DE, 4'b0000, 1);
        for (int i = 0; i < 65534; i++) step(0, 1, 0, 32'hFFFF_FFFF, 4'b0000, 0);
        chk("stall at 65534", bus.stall_cnt_o, 16'hFFFE);
        step(0, 1, 0, 32'hFFFF_FFFF, 4'b0000, 0);
        chk("stall at 65535", bus.stall_cnt_o, 16'hFFFF);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 32'hFFFF_FFFF, 4'b0000, 0);
        chk("stall saturated", bus.stall_cnt_o, 16'hFFFF);
        chk("blocked data0_o", bus.data0_o, 32'hC0DE);

        // Randomized traffic against the model.
        step(1, 0, 0, 0, 4'b0000, 1);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), $urandom, 4'($urandom), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
